// File: rtl/ram_sp_ctrl_defs.sv
// Shared definitions for ram_sp_ctrl: FSM state encodings and default widths.
package ram_sp_ctrl_defs;

  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered read port that holds its value between reads.
// CONTENT is the value the read register takes on reset.
module ram_sp #(
  parameter int                DWIDTH  = 8,
  parameter int                AWIDTH  = 12,
  parameter logic [DWIDTH-1:0] CONTENT = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wren,
  input  logic              rden,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clock) begin
    if (wren) mem[addr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rdata <= CONTENT;
    else if (rden) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Request front end for a single-port RAM with an optional full-memory fill engine.
// The fill engine is built only when RAM_SP_CTRL_CLEAR_EN is defined.
module ram_sp_ctrl
  import ram_sp_ctrl_defs::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_data,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  input  logic              clear_start,
  input  logic [DWIDTH-1:0] clear_value,
  output logic              clear_busy,
  output logic              clear_done
);

  logic              req_accept;
  logic              wren_raw;
  logic              ram_wren;
  logic              ram_rden;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic              rsp_valid_q;

  assign req_accept = req_valid & req_ready;
  assign ram_rden   = req_accept & ~req_write;
  // Keep the RAM write strobe quiet while reset is held, whatever the request inputs do.
  assign ram_wren   = wren_raw & reset_n;

`ifdef RAM_SP_CTRL_CLEAR_EN
  state_t            state_q;
  state_t            state_d;
  logic [AWIDTH-1:0] fill_addr_q;
  logic [DWIDTH-1:0] fill_value_q;
  logic              fill_last;
  logic              clear_done_q;

  // Last write is recognised at all-ones, so the counter never needs to wrap to detect completion.
  assign fill_last = (fill_addr_q == {AWIDTH{1'b1}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_start) state_d = CLEAR;
      CLEAR:   if (fill_last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    clear_busy = 1'b0;
    wren_raw   = 1'b0;
    ram_addr   = req_addr;
    ram_wdata  = req_data;
    case (state_q)
      IDLE: begin
        req_ready = ~clear_start;
        wren_raw  = req_valid & ~clear_start & req_write;
      end
      CLEAR: begin
        clear_busy = 1'b1;
        wren_raw   = 1'b1;
        ram_addr   = fill_addr_q;
        ram_wdata  = fill_value_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_addr_q  <= '0;
      fill_value_q <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= (state_q == CLEAR) && fill_last;
      if (state_q == IDLE && clear_start) begin
        fill_addr_q  <= '0;
        fill_value_q <= clear_value;
      end else if (state_q == CLEAR) begin
        fill_addr_q  <= fill_last ? '0 : fill_addr_q + 1'b1;
      end
    end
  end

  assign clear_done = clear_done_q;
`else
  logic unused_clear;

  assign unused_clear = ^{clear_start, clear_value};
  assign req_ready    = 1'b1;
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
  assign wren_raw     = req_accept & req_write;
  assign ram_addr     = req_addr;
  assign ram_wdata    = req_data;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rsp_valid_q <= 1'b0;
    else          rsp_valid_q <= ram_rden;
  end

  assign rsp_valid = rsp_valid_q;

  ram_sp #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .wren    (ram_wren),
    .rden    (ram_rden),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (rsp_data)
  );

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Directed self-checking bench for ram_sp_ctrl at DWIDTH=8, AWIDTH=4.
// Fill-engine scenarios run when RAM_SP_CTRL_CLEAR_EN is defined, the disabled-build scenario otherwise.
module tb_ram_sp_ctrl;

  logic       clock;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       clear_start;
  logic [7:0] clear_value;
  logic       clear_busy;
  logic       clear_done;

  int checks = 0;
  int errors = 0;

  ram_sp_ctrl #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  initial begin
    reset_n     = 1'b0;
    clear_start = 1'b0;
    clear_value = '0;
    idle_req();
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_clear_done", clear_done, 0);
    reset_n = 1'b1;
    tick();

    // Single write then read of the same address on the next cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_data = 8'hA5;
    chk("wr_ready", req_ready, 1);
    tick();
    chk("wr_no_rsp", rsp_valid, 0);
    req_write = 1'b0;
    tick();
    chk("rd3_valid", rsp_valid, 1);
    chk("rd3_data", rsp_data, 8'hA5);
    idle_req();
    tick();
    chk("rd3_pulse_end", rsp_valid, 0);

    // Fill memory with 15-i, then read back-to-back
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'(i); req_data = 8'(15 - i);
      tick();
      chk("wr_seq_no_rsp", rsp_valid, 0);
    end
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'(i);
      tick();
      chk("rd_seq_valid", rsp_valid, 1);
      chk("rd_seq_data", rsp_data, 32'(15 - i));
    end
    idle_req();
    tick();
    chk("rd_seq_end", rsp_valid, 0);

`ifdef RAM_SP_CTRL_CLEAR_EN
    // Full fill with 0x3C
    clear_start = 1'b1; clear_value = 8'h3C;
    chk("clr_start_ready", req_ready, 0);
    tick();
    clear_start = 1'b0; clear_value = 8'h00;
    for (int c = 0; c < 16; c++) begin
      chk("clr_busy", clear_busy, 1);
      chk("clr_ready_low", req_ready, 0);
      chk("clr_no_done", clear_done, 0);
      chk("clr_no_rsp", rsp_valid, 0);
      tick();
    end
    chk("clr_busy_end", clear_busy, 0);
    chk("clr_done", clear_done, 1);
    chk("clr_ready_back", req_ready, 1);
    tick();
    chk("clr_done_pulse", clear_done, 0);
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'(i);
      tick();
      chk("clr_rd_valid", rsp_valid, 1);
      chk("clr_rd_data", rsp_data, 8'h3C);
    end
    idle_req();
    tick();

    // Clear and write in the same cycle: clear wins
    clear_start = 1'b1; clear_value = 8'h11;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_data = 8'h77;
    chk("race_ready", req_ready, 0);
    tick();
    clear_start = 1'b0;
    idle_req();
    for (int c = 0; c < 16; c++) begin
      chk("race_busy", clear_busy, 1);
      tick();
    end
    chk("race_done", clear_done, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    tick();
    chk("race_rd_valid", rsp_valid, 1);
    chk("race_rd_data", rsp_data, 8'h11);
    idle_req();
    tick();

    // Reset in the middle of a fill
    clear_start = 1'b1; clear_value = 8'h99;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk("mid_busy_before", clear_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", clear_busy, 0);
    chk("mid_rst_done", clear_done, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_ready_after", req_ready, 1);
    chk("mid_busy_after", clear_busy, 0);
    for (int c = 0; c < 12; c++) begin
      chk("mid_no_done", clear_done, 0);
      tick();
    end
`else
    // Fill engine compiled out: clear inputs have no effect
    clear_start = 1'b1; clear_value = 8'h3C;
    chk("noclr_ready", req_ready, 1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("noclr_busy", clear_busy, 0);
      chk("noclr_done", clear_done, 0);
    end
    clear_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'(i);
      tick();
      chk("noclr_rd_valid", rsp_valid, 1);
      chk("noclr_rd_data", rsp_data, 32'(15 - i));
    end
    idle_req();
    tick();
    chk("noclr_rd_end", rsp_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
